shift_seq_unit: RTL and testbench
=================================

Name: shift_seq_unit

Overview:
- Multi-cycle shift/rotate execute stage that sits directly upstream of writeback and downstream of operand fetch.
- It consumes the same operand/mode/amount/carry tuple the combinational ALU shifter takes.
- Iterates one bit per cycle, so all seven shift/rotate modes (including rotate-through-carry) are exact for any 5-bit amount.
- Produces a registered result plus carry/zero/negative flags behind a valid/ready handshake.

Parameters:
- WIDTH, 16, datapath width in bits.
- AMT_W, 5, shift-amount width; amounts 0 to 2^AMT_W-1 are legal.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request.
- in_mode  in  3  000 SHL, 001 ASR, 010 LSR, 011 ROL, 100 ROR, 101 RCL, 110 RCR, 111 reserved.
- in_data  in  WIDTH  operand.
- in_amt  in  AMT_W  shift/rotate count.
- in_carry  in  1  carry flag in.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.
- out_carry  out  1  carry flag out.
- out_zero  out  1  out_data == 0.
- out_neg  out  1  out_data[WIDTH-1].
- busy  out  1  state != IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset: state IDLE; out_data, out_carry, out_zero, out_neg, out_valid, busy all 0. in_ready = 0 while rst is high, and 1 in the first cycle after rst deasserts.
- Reset mid-operation: abort immediately; no result is produced and the latched request is discarded.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready = 1.
  - Accept on in_valid && in_ready: latch data, carry, mode, and count = in_amt.
  - If in_amt == 0 or in_mode == 111, go to DONE; otherwise go to SHIFT.
- SHIFT: in_ready = 0. Each cycle, apply one bit step (d = data reg, c = carry reg, MSB = WIDTH-1):
  - SHL: c <= d[MSB]; d <= {d[MSB-1:0], 0}.
  - ASR: c <= d[0]; d <= {d[MSB], d[MSB:1]}.
  - LSR: c <= d[0]; d <= {0, d[MSB:1]}.
  - ROL: c <= d[MSB]; d <= {d[MSB-1:0], d[MSB]}.
  - ROR: c <= d[0]; d <= {d[0], d[MSB:1]}.
  - RCL: {c, d} <= {d, c} (WIDTH+1-bit rotate).
  - RCR: {d, c} <= {c, d}.
  - count decrements each step; the step taken with count == 1 transitions to DONE.
- DONE:
  - out_valid = 1; out_data/out_carry hold the registered values; out_zero and out_neg are derived from the registered out_data.
  - Outputs hold stable while out_ready = 0.
  - On out_valid && out_ready, go to IDLE.
  - No accept in DONE: in_ready = 0, so back-to-back requests cost one bubble.
- Latency: out_valid rises N+1 cycles after the accept edge for amount N ≥ 1, and 1 cycle after for N = 0 or mode 111.
- Throughput: one request per N+2 cycles, or 2 cycles for N = 0.
- Amount 0 or mode 111: out_data = in_data, out_carry = in_carry.
- Large amounts, all iterated literally:
  - SHL/LSR with N ≥ WIDTH give 0; carry is the last bit shifted out (0 once N > WIDTH).
  - ASR saturates to all sign bits.
  - ROL/ROR have period WIDTH.
  - RCL/RCR have period WIDTH+1.
- Input changes after acceptance are ignored; the request is fully latched.

Decomposition:
- Shared package holds:
  - mode encodings SHL..RCR and the reserved code;
  - state encodings IDLE/SHIFT/DONE;
  - default WIDTH/AMT_W constants.
- One natural sub-module: shift_step, a combinational single-bit step (mode, d, c -> d', c').
- The FSM, counter and handshake live in shift_seq_unit.

Test Plan:
- SHL 0x8001 amt 1 carry 0, out_ready = 1 -> out_valid 2 cycles after accept; 0x0002, carry 1, zero 0, neg 0.
- ASR 0x8000 amt 4 -> 0xF800, carry 0, neg 1. LSR 0x8000 amt 4 -> 0x0800.
- ROR 0x0001 amt 1 -> 0x8000, carry 1, neg 1. RCL 0x8000 carry 0 amt 17 -> 0x8000, carry 0 (full period). RCL 0x8000 carry 0 amt 1 -> 0x0000, carry 1, zero 1.
- amt 0, mode ROL, 0x1234, carry 1 -> 0x1234, carry 1, out_valid 1 cycle after accept. Mode 111 behaves the same.
- Backpressure: SHL 0x0001 amt 3, out_ready low 5 cycles -> out_data 0x0008 held stable with out_valid high; in_ready stays 0 until the handshake; IDLE the cycle after.
- Reset mid-op: LSR 0xFFFF amt 20, rst for 1 cycle at cycle 5 -> no out_valid, outputs 0; a new request afterwards completes normally (LSR 0xFFFF amt 20 -> 0x0000, carry 0, zero 1).

Source files
------------

// File: rtl/shift_seq_unit_pkg.sv
// Shared encodings for the iterative shift/rotate stage.
// Modes, FSM states and default widths.
package shift_seq_unit_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int AMT_W_DEF = 5;

  typedef enum logic [2:0] {
    MODE_SHL = 3'b000,
    MODE_ASR = 3'b001,
    MODE_LSR = 3'b010,
    MODE_ROL = 3'b011,
    MODE_ROR = 3'b100,
    MODE_RCL = 3'b101,
    MODE_RCR = 3'b110,
    MODE_RSV = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_seq_unit_step.sv
// One-bit shift/rotate step, purely combinational.
// Reserved mode passes data and carry through.
module shift_step
  import shift_seq_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  mode_e            i_mode,
  input  logic [WIDTH-1:0] i_d,
  input  logic             i_c,
  output logic [WIDTH-1:0] o_d,
  output logic             o_c
);

  localparam int MSB = WIDTH - 1;

  // single-bit step for the selected mode
  always_comb begin
    o_d = i_d;
    o_c = i_c;
    unique case (i_mode)
      MODE_SHL: begin
        o_c = i_d[MSB];
        o_d = {i_d[MSB-1:0], 1'b0};
      end
      MODE_ASR: begin
        o_c = i_d[0];
        o_d = {i_d[MSB], i_d[MSB:1]};
      end
      MODE_LSR: begin
        o_c = i_d[0];
        o_d = {1'b0, i_d[MSB:1]};
      end
      MODE_ROL: begin
        o_c = i_d[MSB];
        o_d = {i_d[MSB-1:0], i_d[MSB]};
      end
      MODE_ROR: begin
        o_c = i_d[0];
        o_d = {i_d[0], i_d[MSB:1]};
      end
      MODE_RCL: begin
        o_c = i_d[MSB];
        o_d = {i_d[MSB-1:0], i_c};
      end
      MODE_RCR: begin
        o_c = i_d[0];
        o_d = {i_c, i_d[MSB:1]};
      end
      default: begin
        o_d = i_d;
        o_c = i_c;
      end
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle shift/rotate execute stage.
// One bit per cycle, result held behind valid/ready.
module shift_seq_unit
  import shift_seq_unit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int AMT_W = AMT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             busy
);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_data;
  logic             r_carry;
  mode_e            r_mode;
  logic [AMT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_step_d;
  logic             w_step_c;
  logic             w_accept;
  logic             w_bypass;

  assign w_accept = in_valid && in_ready;
  assign w_bypass = (in_amt == '0) ||
                    (in_mode == MODE_RSV);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_mode (r_mode),
    .i_d    (r_data),
    .i_c    (r_carry),
    .o_d    (w_step_d),
    .o_c    (w_step_c)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // next-state: count of 1 marks the final step
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept)
          w_next = w_bypass ? ST_DONE : ST_SHIFT;
      end
      ST_SHIFT: begin
        if (r_cnt == AMT_W'(1)) w_next = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // outputs: flags only meaningful while a result is presented
  always_comb begin
    in_ready  = (r_state == ST_IDLE) && !rst;
    out_valid = (r_state == ST_DONE);
    busy      = (r_state != ST_IDLE);
    out_data  = r_data;
    out_carry = r_carry;
    out_zero  = out_valid && (r_data == '0);
    out_neg   = out_valid && r_data[WIDTH-1];
  end

  // datapath: latch request, then step once per SHIFT cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_carry <= 1'b0;
      r_mode  <= MODE_SHL;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_data  <= in_data;
      r_carry <= in_carry;
      r_mode  <= mode_e'(in_mode);
      r_cnt   <= in_amt;
    end else if (r_state == ST_SHIFT) begin
      r_data  <= w_step_d;
      r_carry <= w_step_c;
      r_cnt   <= r_cnt - AMT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_seq_unit.sv
// Scoreboard bench for shift_seq_unit.
// Directed cases plus randomized traffic vs reference model.
module tb_shift_seq_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [15:0] in_data;
  logic [4:0]  in_amt;
  logic        in_carry;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_carry;
  logic        out_zero;
  logic        out_neg;
  logic        busy;

  shift_seq_unit #(.WIDTH(16), .AMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .in_amt    (in_amt),
    .in_carry  (in_carry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_carry (out_carry),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic        c;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   rdy_mode = 1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h",
               nm, act, req);
    end
  endtask

  // reference: whole-count arithmetic, returns {carry, data}
  function automatic logic [16:0] model(
    input logic [2:0] m, input logic [15:0] d,
    input logic c, input int n);
    logic [63:0]        w;
    logic signed [15:0] s;
    logic [15:0]        r;
    logic               cc;
    int                 k;
    if (n == 0 || m == 3'd7) return {c, d};
    r = d; cc = c;
    case (m)
      3'd0: begin
        w = 64'(d) << n;
        r = w[15:0]; cc = w[16];
      end
      3'd1: begin
        s = d;
        r = 16'(s >>> n);
        cc = (n <= 16) ? d[n-1] : d[15];
      end
      3'd2: begin
        r = 16'(32'(d) >> n);
        cc = (n <= 16) ? d[n-1] : 1'b0;
      end
      3'd3: begin
        k = n % 16;
        r = 16'((32'(d) << k) | (32'(d) >> (16 - k)));
        cc = r[0];
      end
      3'd4: begin
        k = n % 16;
        r = 16'((32'(d) >> k) | (32'(d) << (16 - k)));
        cc = r[15];
      end
      3'd5: begin
        k = n % 17;
        w = 64'({c, d});
        w = (w << k) | (w >> (17 - k));
        r = w[15:0]; cc = w[16];
      end
      default: begin
        k = n % 17;
        w = 64'({c, d});
        w = (w >> k) | (w << (17 - k));
        r = w[15:0]; cc = w[16];
      end
    endcase
    return {cc, r};
  endfunction

  // issue one request; expectation queued at the accept
  task automatic send(logic [2:0] m, logic [15:0] d,
                      logic [4:0] a, logic c,
                      bit use_k, logic [15:0] kd,
                      logic kc, bit want);
    bit          got;
    logic [16:0] e;
    exp_t        x;
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = m;
    in_data = d; in_amt = a; in_carry = c;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (in_ready) begin got = 1'b1; break; end
    end
    if (!got) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else if (want) begin
      e = model(m, d, c, int'(a));
      x.d = use_k ? kd : e[15:0];
      x.c = use_k ? kc : e[16];
      x.lat = (a == 5'd0 || m == 3'd7) ? 1 : int'(a) + 1;
      x.acc = cyc + 1;
      sbq.push_back(x);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_mode  = 3'($urandom);
    in_data  = 16'($urandom);
    in_amt   = 5'($urandom);
    in_carry = 1'($urandom);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (sbq.size() == 0 && !busy) begin
        ok = 1'b1; break;
      end
    end
    if (!ok) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       out_ready = 1'($urandom_range(0, 1));
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
  end

  // monitor: pops on handshake, checks latency and hold
  initial begin
    bit          pv, phs;
    logic [15:0] pd;
    logic        pc;
    exp_t        x;
    pv = 0; phs = 0; pd = '0; pc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; phs = 0;
      end else begin
        if (out_valid) begin
          chk("in_ready_in_done", 32'(in_ready), 32'd0);
          chk("busy_in_done", 32'(busy), 32'd1);
          if (sbq.size() == 0) begin
            chk("unexpected_valid", 32'(out_valid), 32'd0);
          end else begin
            x = sbq[0];
            if (!pv)
              chk("latency", 32'(cyc - x.acc + 1),
                  32'(x.lat));
            else if (!phs) begin
              chk("hold_data", 32'(out_data), 32'(pd));
              chk("hold_carry", 32'(out_carry), 32'(pc));
            end
            if (out_ready) begin
              void'(sbq.pop_front());
              chk("data", 32'(out_data), 32'(x.d));
              chk("carry", 32'(out_carry), 32'(x.c));
              chk("zero", 32'(out_zero),
                  32'(x.d == 16'd0));
              chk("neg", 32'(out_neg), 32'(x.d[15]));
            end
          end
        end
        pv  = out_valid;
        phs = out_valid && out_ready;
        pd  = out_data;
        pc  = out_carry;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int r;
    logic [4:0] a;
    rst = 1'b1; in_valid = 1'b0; in_mode = '0;
    in_data = '0; in_amt = '0; in_carry = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_flags",
        32'({out_carry, out_zero, out_neg}), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    rdy_mode = 1;
    send(3'd0, 16'h8001, 5'd1, 1'b0, 1, 16'h0002, 1'b1, 1);
    send(3'd1, 16'h8000, 5'd4, 1'b0, 1, 16'hF800, 1'b0, 1);
    send(3'd2, 16'h8000, 5'd4, 1'b0, 1, 16'h0800, 1'b0, 1);
    send(3'd4, 16'h0001, 5'd1, 1'b0, 1, 16'h8000, 1'b1, 1);
    send(3'd5, 16'h8000, 5'd17, 1'b0, 1, 16'h8000, 1'b0, 1);
    send(3'd5, 16'h8000, 5'd1, 1'b0, 1, 16'h0000, 1'b1, 1);
    send(3'd3, 16'h1234, 5'd0, 1'b1, 1, 16'h1234, 1'b1, 1);
    send(3'd7, 16'h1234, 5'd9, 1'b1, 1, 16'h1234, 1'b1, 1);
    send(3'd0, 16'hFFFF, 5'd16, 1'b0, 1, 16'h0000, 1'b1, 1);
    send(3'd0, 16'hFFFF, 5'd17, 1'b1, 1, 16'h0000, 1'b0, 1);
    send(3'd1, 16'h8000, 5'd31, 1'b0, 1, 16'hFFFF, 1'b1, 1);
    send(3'd3, 16'hA5C3, 5'd16, 1'b0, 1, 16'hA5C3, 1'b1, 1);
    drain();

    rdy_mode = 2;
    send(3'd0, 16'h0001, 5'd3, 1'b0, 1, 16'h0008, 1'b0, 1);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid) begin ok = 1'b1; break; end
    end
    chk("bp_valid_seen", 32'(ok), 32'd1);
    repeat (5) @(negedge clk);
    chk("bp_hold_valid", 32'(out_valid), 32'd1);
    chk("bp_hold_data", 32'(out_data), 32'h0008);
    rdy_mode = 1;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        ok = 1'b1; break;
      end
    end
    chk("bp_handshake", 32'(ok), 32'd1);
    @(negedge clk);
    chk("bp_idle_busy", 32'(busy), 32'd0);
    chk("bp_idle_ready", 32'(in_ready), 32'd1);

    send(3'd2, 16'hFFFF, 5'd20, 1'b0, 0, 16'h0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_data", 32'(out_data), 32'd0);
    chk("midrst_flags",
        32'({out_carry, out_zero, out_neg}), 32'd0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    repeat (30) @(negedge clk);
    send(3'd2, 16'hFFFF, 5'd20, 1'b0, 1, 16'h0000, 1'b0, 1);
    drain();

    rdy_mode = 0;
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 9);
      case (r)
        0:       a = 5'd0;
        1:       a = 5'd16;
        2:       a = 5'd17;
        3:       a = 5'd31;
        default: a = 5'($urandom);
      endcase
      send(3'($urandom_range(0, 7)), 16'($urandom), a,
           1'($urandom), 0, 16'h0, 1'b0, 1);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
